lb_uart_rx_datapath: RTL and testbench

Receive datapath directly downstream of lb_UART_Rx_ControlUnit. Samples rx on each shift pulse from the control unit and assembles the serial frame. On done it extracts the data byte, checks parity and stop bit, and pushes the result into a small first-word-fall-through FIFO. The PicoBlaze port logic reads data and status from that FIFO.

---
 rtl/lb_uart_pkg.sv | 23 ++
 rtl/lb_uart_rx_datapath_if.sv | 28 ++
 rtl/lb_uart_rx_fifo.sv | 70 +++++++
 rtl/lb_uart_rx_datapath.sv | 78 +++++++
 tb/tb_lb_uart_rx_datapath.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/lb_uart_pkg.sv
// Shared constants, entry layout and parity helper for the UART receive path.
package lb_uart_pkg;

   localparam int SR_W     = 11;
   localparam int ENTRY_W  = 10;
   localparam int DATA_LSB = 0;
   localparam int PERR_BIT = 8;
   localparam int FERR_BIT = 9;

   typedef struct packed {
      logic       ferr;
      logic       perr;
      logic [7:0] data;
   } rx_entry_t;

   // True when data plus parity bit do not give the requested parity sense.
   function automatic logic parity_mismatch(input logic [7:0] data,
                                            input logic       par_bit,
                                            input logic       odd_n_even);
      return (((^data) ^ par_bit) != odd_n_even);
   endfunction

endpackage

// File: rtl/lb_uart_rx_datapath_if.sv
// Control-unit and host-port signals of the UART receive datapath.
interface lb_uart_rx_datapath_if #(parameter int CNT_W = 3) ();

   logic             rx;
   logic             shift;
   logic             done;
   logic             bit8;
   logic             parity_en;
   logic             odd_n_even;
   logic             rd_strobe;
   logic [7:0]       rx_data;
   logic             rx_rdy;
   logic             perr;
   logic             ferr;
   logic             ovf;
   logic [CNT_W-1:0] rx_count;

   modport master (
      output rx, shift, done, bit8, parity_en, odd_n_even, rd_strobe,
      input  rx_data, rx_rdy, perr, ferr, ovf, rx_count
   );

   modport slave (
      input  rx, shift, done, bit8, parity_en, odd_n_even, rd_strobe,
      output rx_data, rx_rdy, perr, ferr, ovf, rx_count
   );

endinterface

// File: rtl/lb_uart_rx_fifo.sv
// First-word-fall-through FIFO for received frames; head is read straight from storage.
module lb_uart_rx_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int ENTRY_W    = 10,
   parameter int CNT_W      = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] wr_data,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               rdy,
   output logic [CNT_W-1:0]   count,
   output logic               overrun
);

   localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic [CNT_W-1:0]   count_next_s;
   logic               rdy_r;
   logic               pop_s;
   logic               wr_s;
   logic               full_s;

   // Accept/drop decision: a pop frees the slot a full-FIFO push needs.
   always_comb begin
      full_s  = (count_r == CNT_FULL);
      pop_s   = pop & rdy_r;
      wr_s    = push & (~full_s | pop_s);
      overrun = push & full_s & ~pop_s;
      case ({wr_s, pop_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         default: count_next_s = count_r;
      endcase
   end

   // Pointer, occupancy and ready state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         rdy_r    <= 1'b0;
      end else begin
         if (wr_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
         count_r <= count_next_s;
         rdy_r   <= (count_next_s != {CNT_W{1'b0}});
      end
   end

   // Entry storage; stale contents are masked by rdy on the read side.
   always_ff @(posedge clk) begin
      if (wr_s) mem_r[wr_ptr_r] <= wr_data;
   end

   assign rd_data = rdy_r ? mem_r[rd_ptr_r] : {ENTRY_W{1'b0}};
   assign rdy     = rdy_r;
   assign count   = count_r;

endmodule

// File: rtl/lb_uart_rx_datapath.sv
// UART receive datapath: frame shift register, data/parity/stop extraction and frame FIFO.
module lb_uart_rx_datapath
   import lb_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   lb_uart_rx_datapath_if.slave  bus
);

   logic [SR_W-1:0]    sr_r;
   logic [SR_W-1:0]    sr_next_s;
   logic [SR_W-1:0]    frame_s;
   logic [3:0]         len_s;
   logic [7:0]         data_s;
   logic               par_bit_s;
   rx_entry_t          entry_s;
   logic [ENTRY_W-1:0] head_s;
   logic               overrun_s;
   logic               ovf_r;

   // A shift coinciding with done must be visible to extraction in that cycle.
   always_comb begin
      if (bus.shift) sr_next_s = {bus.rx, sr_r[SR_W-1:1]};
      else sr_next_s = sr_r;
   end

   // Right-align the frame so start lands in bit 0 and stop in bit len-1.
   always_comb begin
      len_s   = 4'd9 + {3'b000, bus.bit8} + {3'b000, bus.parity_en};
      frame_s = sr_next_s >> (4'd11 - len_s);
      if (bus.bit8) data_s = frame_s[8:1];
      else data_s = {1'b0, frame_s[7:1]};
      if (bus.parity_en) par_bit_s = frame_s[len_s - 4'd2];
      else par_bit_s = 1'b0;
      entry_s.data = data_s;
      entry_s.perr = bus.parity_en & parity_mismatch(data_s, par_bit_s, bus.odd_n_even);
      entry_s.ferr = ~frame_s[len_s - 4'd1];
   end

   // Serial frame capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sr_r <= {SR_W{1'b1}};
      else sr_r <= sr_next_s;
   end

   // Sticky overrun; a same-cycle overrun beats the clear from a read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ovf_r <= 1'b0;
      else if (overrun_s) ovf_r <= 1'b1;
      else if (bus.rd_strobe) ovf_r <= 1'b0;
      else ovf_r <= ovf_r;
   end

   lb_uart_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .ENTRY_W    (ENTRY_W),
      .CNT_W      (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (bus.done),
      .pop     (bus.rd_strobe),
      .wr_data (entry_s),
      .rd_data (head_s),
      .rdy     (bus.rx_rdy),
      .count   (bus.rx_count),
      .overrun (overrun_s)
   );

   assign bus.rx_data = head_s[DATA_LSB +: 8];
   assign bus.perr    = head_s[PERR_BIT];
   assign bus.ferr    = head_s[FERR_BIT];
   assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_lb_uart_rx_datapath.sv
// Directed plus randomized bench; expectations come from a frame-level queue model.
module tb_lb_uart_rx_datapath;

   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lb_uart_rx_datapath_if #(.CNT_W(CW)) bus ();

   lb_uart_rx_datapath #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         tests = 0;
   int         fails = 0;
   int         rd_pct = 0;
   logic [9:0] mq[$];
   logic       m_ovf = 1'b0;
   logic [9:0] pend = 10'd0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [9:0] h;
      h = (mq.size() != 0) ? mq[0] : 10'd0;
      check({tag, ".rdy"},   {15'd0, bus.rx_rdy}, {15'd0, mq.size() != 0});
      check({tag, ".count"}, {13'd0, bus.rx_count}, 16'(mq.size()));
      check({tag, ".ovf"},   {15'd0, bus.ovf}, {15'd0, m_ovf});
      check({tag, ".data"},  {8'd0, bus.rx_data}, {8'd0, h[7:0]});
      check({tag, ".perr"},  {15'd0, bus.perr}, {15'd0, h[8]});
      check({tag, ".ferr"},  {15'd0, bus.ferr}, {15'd0, h[9]});
   endtask

   function automatic logic rnd_rd();
      return ($urandom_range(0, 99) < rd_pct);
   endfunction

   // One clock: drive strobes, advance, update the queue model, compare.
   task automatic cycle(input logic sh, input logic rxb, input logic dn, input logic rd,
                        input string tag);
      logic pop_ok;
      bus.shift = sh; bus.rx = rxb; bus.done = dn; bus.rd_strobe = rd;
      @(posedge clk); #1;
      bus.shift = 1'b0; bus.done = 1'b0; bus.rd_strobe = 1'b0; bus.rx = 1'b1;
      pop_ok = rd && (mq.size() != 0);
      if (dn && mq.size() == DEPTH && !pop_ok) begin
         m_ovf = 1'b1;
      end else begin
         if (pop_ok) void'(mq.pop_front());
         if (dn) mq.push_back(pend);
         if (rd) m_ovf = 1'b0;
      end
      check_all(tag);
   endtask

   task automatic send(input logic [7:0] d, input logic b8, input logic pe, input logic odd,
                       input logic pbit, input logic stop, input logic merge,
                       input logic rd_done, input string tag);
      logic       bits[$];
      logic [7:0] dbits;
      int         nb;
      bus.bit8 = b8; bus.parity_en = pe; bus.odd_n_even = odd;
      nb    = b8 ? 8 : 7;
      dbits = b8 ? d : {1'b0, d[6:0]};
      pend  = {~stop, pe & ((($countones(dbits) + int'(pbit)) % 2) != int'(odd)), dbits};
      bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) bits.push_back(d[i]);
      if (pe) bits.push_back(pbit);
      bits.push_back(stop);
      for (int i = 0; i < bits.size() - 1; i++) cycle(1'b1, bits[i], 1'b0, rnd_rd(), tag);
      if (merge) begin
         cycle(1'b1, bits[bits.size() - 1], 1'b1, rd_done, tag);
      end else begin
         cycle(1'b1, bits[bits.size() - 1], 1'b0, rnd_rd(), tag);
         cycle(1'b0, 1'b1, 1'b1, rd_done, tag);
      end
   endtask

   initial begin
      bus.rx = 1'b1; bus.shift = 1'b0; bus.done = 1'b0; bus.rd_strobe = 1'b0;
      bus.bit8 = 1'b1; bus.parity_en = 1'b0; bus.odd_n_even = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      reset = 1'b0;

      // 8N1 0x5A, then pop
      send(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "8n1_5a");
      cycle(1'b0, 1'b1, 1'b0, 1'b1, "8n1_pop");

      // 8E1 / 8O1 parity cases
      send(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "8e1_bad");
      cycle(1'b0, 1'b1, 1'b0, 1'b1, "pop1");
      send(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "8e1_good");
      cycle(1'b0, 1'b1, 1'b0, 1'b1, "pop2");
      send(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "8o1_good");
      cycle(1'b0, 1'b1, 1'b0, 1'b1, "pop3");

      // 7N1 with framing error
      send(8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "7n1_ferr");
      cycle(1'b0, 1'b1, 1'b0, 1'b1, "pop4");

      // Overrun: five frames into depth four, then drain
      for (int i = 0; i < 5; i++)
         send(8'h11 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ovf_fill");
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, "ovf_drain");

      // Full FIFO with push and pop together
      for (int i = 0; i < 4; i++)
         send(8'h21 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "full_fill");
      send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "full_pushpop");
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, "full_drain");
      cycle(1'b0, 1'b1, 1'b0, 1'b1, "empty_rd");

      // Empty FIFO with push and read together
      send(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "empty_pushpop");

      // Reset mid-frame with a held entry, then a clean frame
      bus.bit8 = 1'b1; bus.parity_en = 1'b0;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, "partial");
      reset = 1'b1;
      #2;
      mq.delete();
      m_ovf = 1'b0;
      check_all("rst_async");
      @(posedge clk); #1;
      reset = 1'b0;
      send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "after_rst");

      // Randomized frames, modes and reads
      rd_pct = 25;
      for (int n = 0; n < 60; n++) begin
         send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), "rand");
         for (int k = $urandom_range(0, 3); k > 0; k--)
            cycle(1'b0, 1'b1, 1'b0, rnd_rd(), "rand_idle");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
